// File: rtl/lsu_mem_port_pkg.sv
// Shared LSU constants: memory alucodes, FSM states, access sizes.
// Also holds small decode helpers used by the LSU datapath.
package lsu_mem_port_pkg;

  localparam logic [5:0] ALU_LB  = 6'd11;
  localparam logic [5:0] ALU_LH  = 6'd12;
  localparam logic [5:0] ALU_LW  = 6'd13;
  localparam logic [5:0] ALU_LBU = 6'd14;
  localparam logic [5:0] ALU_LHU = 6'd15;
  localparam logic [5:0] ALU_SB  = 6'd16;
  localparam logic [5:0] ALU_SH  = 6'd17;
  localparam logic [5:0] ALU_SW  = 6'd18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  function automatic logic is_store(input logic [5:0] op);
    return op inside {ALU_SB, ALU_SH, ALU_SW};
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU,
                      ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
  endfunction

  function automatic lsu_size_e op_size(input logic [5:0] op);
    if (op inside {ALU_LB, ALU_LBU, ALU_SB})
      return SZ_B;
    if (op inside {ALU_LH, ALU_LHU, ALU_SH})
      return SZ_H;
    return SZ_W;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// LSU lane logic: byte enables, store replication, alignment check,
// and load byte/half select with sign or zero extension.
module lsu_align
  import lsu_mem_port_pkg::*;
(
  input  logic [5:0]  req_code,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [5:0]  ld_code,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  lsu_size_e   sz;
  logic [31:0] lane;

  assign sz = op_size(req_code);

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = req_wdata;
    unique case (sz)
      SZ_B: begin
        be    = 4'b0001 << req_off;
        wdata = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        be         = 4'b0011 << req_off;
        wdata      = {2{req_wdata[15:0]}};
        misaligned = req_off[0];
      end
      default: misaligned = |req_off;
    endcase
  end

  assign lane = ld_word >> {ld_off, 3'b000};

  // Stores and non-memory codes fall through to zero.
  always_comb begin
    ld_data = '0;
    unique case (ld_code)
      ALU_LB:  ld_data = {{24{lane[7]}}, lane[7:0]};
      ALU_LH:  ld_data = {{16{lane[15]}}, lane[15:0]};
      ALU_LBU: ld_data = {24'd0, lane[7:0]};
      ALU_LHU: ld_data = {16'd0, lane[15:0]};
      ALU_LW:  ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit: request accept, single-outstanding bus access,
// timeout to bus error, and one-cycle response to writeback.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_alucode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_buserr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1
                       : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       r_code;
  logic [1:0]       r_off;
  logic             misaligned;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      ld_data;
  logic             timeout;

  lsu_align u_align (
    .req_code   (req_alucode),
    .req_off    (req_addr[1:0]),
    .req_wdata  (req_wdata),
    .misaligned (misaligned),
    .be         (be),
    .wdata      (wdata),
    .ld_code    (r_code),
    .ld_off     (r_off),
    .ld_word    (mem_rdata),
    .ld_data    (ld_data)
  );

  assign req_ready = (state == ST_IDLE);
  assign timeout   = TO_EN && (cnt >= CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      r_code          <= '0;
      r_off           <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_buserr     <= 1'b0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_be          <= '0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_code <= req_alucode;
            r_off  <= req_addr[1:0];
            if (!is_mem(req_alucode)) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
            end else if (misaligned) begin
              state           <= ST_RESP;
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
            end else begin
              state     <= ST_BUS;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store(req_alucode);
              mem_be    <= be;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= wdata;
            end
          end
        end
        ST_BUS: begin
          // An ack on the expiry cycle still wins over the timeout.
          if (mem_ack) begin
            state      <= ST_RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
          end else if (timeout) begin
            state       <= ST_RESP;
            mem_req     <= 1'b0;
            resp_valid  <= 1'b1;
            resp_rdata  <= '0;
            resp_buserr <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state           <= ST_IDLE;
          resp_valid      <= 1'b0;
          resp_rdata      <= '0;
          resp_misaligned <= 1'b0;
          resp_buserr     <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
